resp_compactor: RTL

- Response-capture stage directly downstream of a gate-under-test in the fault-simulation flow.
- Accepts one DUT response per applied pattern and compares it against the expected (fault-free) value.
- Counts mismatches, records the index of the first failing pattern, and folds every response into a MISR signature.
- The pattern driver or bench reads the fault-detected status and signature after the last pattern.

---
 rtl/resp_compactor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/resp_compactor.sv
// resp_compactor: response-capture stage for fault simulation.
// Compares each accepted DUT response against its fault-free value, counts
// mismatches, records the first failing pattern index and, when the macro
// RESP_COMPACTOR_MISR_EN is defined, folds every response into a MISR
// signature. Without that macro the signature output is tied to SEED.
module resp_compactor #(
    parameter int unsigned      WIDTH = 1,
    parameter int unsigned      CNT_W = 16,
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 'h1021,
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pat_valid,
    input  logic [WIDTH-1:0] resp,
    input  logic [WIDTH-1:0] exp,
    input  logic             last,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] pat_idx,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [SIG_W-1:0] sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             fail_q;
    logic [CNT_W-1:0] mismatch_cnt_q;
    logic [CNT_W-1:0] pat_idx_q;
    logic [CNT_W-1:0] first_fail_idx_q;

    logic             accept;
    logic             session_start;
    logic             mismatch;
    logic [CNT_W-1:0] pat_idx_d;
    logic [CNT_W-1:0] mismatch_cnt_d;

    // A start is honoured only outside RUN; patterns only count inside RUN.
    assign accept        = (state_q == RUN) && pat_valid;
    assign session_start = (state_q != RUN) && start;
    assign mismatch      = (resp != exp);

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign pat_idx_d      = (pat_idx_q == '1) ? pat_idx_q : pat_idx_q + CNT_W'(1);
    assign mismatch_cnt_d = (mismatch_cnt_q == '1) ? mismatch_cnt_q
                                                   : mismatch_cnt_q + CNT_W'(1);

    // Session FSM with registered status outputs and the compare/count datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            fail_q           <= 1'b0;
            mismatch_cnt_q   <= '0;
            pat_idx_q        <= '0;
            first_fail_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q          <= RUN;
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        fail_q           <= 1'b0;
                        mismatch_cnt_q   <= '0;
                        pat_idx_q        <= '0;
                        first_fail_idx_q <= '0;
                    end
                end
                RUN: begin
                    if (pat_valid) begin
                        pat_idx_q <= pat_idx_d;
                        if (mismatch) begin
                            mismatch_cnt_q <= mismatch_cnt_d;
                            if (!fail_q) begin
                                fail_q           <= 1'b1;
                                first_fail_idx_q <= pat_idx_q;
                            end
                        end
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESP_COMPACTOR_MISR_EN
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    assign sig_d = {sig_q[SIG_W-2:0], 1'b0}
                 ^ (sig_q[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(resp);

    // MISR: reseeded by a session start, shifted once per accepted pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= SEED;
        end else if (session_start) begin
            sig_q <= SEED;
        end else if (accept) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    logic unused_ctl;
    assign unused_ctl = session_start ^ accept;
    assign sig        = SEED;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign fail           = fail_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign pat_idx        = pat_idx_q;
    assign first_fail_idx = first_fail_idx_q;

endmodule
